// File: rtl/interval_timer_if.sv
// Control/status bundle between a phase FSM (master) and one interval_timer (slave).
interface interval_timer_if #(
    parameter int COUNTER_WIDTH = 8
);
    logic                     start;
    logic                     pause;
    logic                     abort;
    logic                     auto_reload;
    logic [COUNTER_WIDTH-1:0] terminal;
    logic [COUNTER_WIDTH-1:0] counter;
    logic                     busy;
    logic                     tick;
    logic                     done;

    modport master (
        output start, pause, abort, auto_reload, terminal,
        input  counter, busy, tick, done
    );

    modport slave (
        input  start, pause, abort, auto_reload, terminal,
        output counter, busy, tick, done
    );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer with prescaler, one-shot/auto-reload, pause and abort.
// All outputs are registered; done/tick are single-cycle pulses on the step edge.
module interval_timer #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_DIV   = 100_000_000,
    parameter int PRESCALE_WIDTH = 27
) (
    input  logic              clk,
    input  logic              reset,
    interval_timer_if.slave   tmr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(PRESCALE_DIV - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ZERO = PRESCALE_WIDTH'(0);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE  = PRESCALE_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0]  COUNT_ZERO    = COUNTER_WIDTH'(0);
    localparam logic [COUNTER_WIDTH-1:0]  COUNT_ONE     = COUNTER_WIDTH'(1);

    state_t                    state_r;
    logic [COUNTER_WIDTH-1:0]  term_reg_r;
    logic [PRESCALE_WIDTH-1:0] prescaler_r;
    logic [COUNTER_WIDTH-1:0]  counter_r;
    logic                      busy_r;
    logic                      tick_r;
    logic                      done_r;

    // Interval sequencing: abort > start > pause > prescaled step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            term_reg_r  <= COUNT_ZERO;
            prescaler_r <= PRESCALE_ZERO;
            counter_r   <= COUNT_ZERO;
            busy_r      <= 1'b0;
            tick_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            if (tmr.abort) begin
                state_r     <= IDLE;
                counter_r   <= COUNT_ZERO;
                prescaler_r <= PRESCALE_ZERO;
                busy_r      <= 1'b0;
            end else if (tmr.start) begin
                counter_r   <= COUNT_ZERO;
                prescaler_r <= PRESCALE_ZERO;
                if (tmr.terminal == COUNT_ZERO) begin
                    // A zero-length interval completes immediately without ever running.
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end else begin
                    term_reg_r <= tmr.terminal;
                    busy_r     <= 1'b1;
                    state_r    <= tmr.pause ? HOLD : RUN;
                end
            end else begin
                case (state_r)
                    // Leaving HOLD advances in the same cycle, so each HOLD cycle costs exactly one.
                    RUN, HOLD: begin
                        if (tmr.pause) begin
                            state_r <= HOLD;
                        end else if (prescaler_r != PRESCALE_LAST) begin
                            state_r     <= RUN;
                            prescaler_r <= prescaler_r + PRESCALE_ONE;
                        end else begin
                            prescaler_r <= PRESCALE_ZERO;
                            tick_r      <= 1'b1;
                            if (counter_r < (term_reg_r - COUNT_ONE)) begin
                                state_r   <= RUN;
                                counter_r <= counter_r + COUNT_ONE;
                            end else if (tmr.auto_reload) begin
                                state_r   <= RUN;
                                counter_r <= COUNT_ZERO;
                                done_r    <= 1'b1;
                            end else begin
                                state_r   <= IDLE;
                                counter_r <= term_reg_r;
                                done_r    <= 1'b1;
                                busy_r    <= 1'b0;
                            end
                        end
                    end
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tmr.counter = counter_r;
    assign tmr.busy    = busy_r;
    assign tmr.tick    = tick_r;
    assign tmr.done    = done_r;

endmodule

// File: tb/tb_interval_timer.sv
// Drives a DIV=4 and a DIV=1 interval_timer with identical inputs and checks both
// against an arithmetic model (elapsed run cycles / DIV = steps; steps mod T = counter).
module tb_interval_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       abort;
    logic       auto_reload;
    logic [7:0] terminal;

    int tests_run;
    int tests_failed;

    interval_timer_if #(.COUNTER_WIDTH(8)) ia ();
    interval_timer_if #(.COUNTER_WIDTH(8)) ib ();

    assign ia.start       = start;
    assign ia.pause       = pause;
    assign ia.abort       = abort;
    assign ia.auto_reload = auto_reload;
    assign ia.terminal    = terminal;
    assign ib.start       = start;
    assign ib.pause       = pause;
    assign ib.abort       = abort;
    assign ib.auto_reload = auto_reload;
    assign ib.terminal    = terminal;

    interval_timer #(.COUNTER_WIDTH(8), .PRESCALE_DIV(4), .PRESCALE_WIDTH(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tmr   (ia.slave)
    );

    interval_timer #(.COUNTER_WIDTH(8), .PRESCALE_DIV(1), .PRESCALE_WIDTH(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tmr   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = DIV 4, index 1 = DIV 1.
    int m_div [2];
    bit m_act [2];
    int m_el  [2];
    int m_t   [2];
    int m_cnt [2];
    bit m_tick[2];
    bit m_done[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 1'b0; m_el[m] = 0; m_t[m] = 0; m_cnt[m] = 0;
            m_tick[m] = 1'b0; m_done[m] = 1'b0;
        end
    endtask

    task automatic model_edge(input int m);
        int steps;
        m_tick[m] = 1'b0;
        m_done[m] = 1'b0;
        if (abort) begin
            m_act[m] = 1'b0;
            m_cnt[m] = 0;
        end else if (start) begin
            m_cnt[m] = 0;
            if (terminal == 8'd0) begin
                m_act[m]  = 1'b0;
                m_done[m] = 1'b1;
            end else begin
                m_act[m] = 1'b1;
                m_t[m]   = int'(terminal);
                m_el[m]  = 0;
            end
        end else if (m_act[m] && !pause) begin
            m_el[m]++;
            if (m_el[m] % m_div[m] == 0) begin
                m_tick[m] = 1'b1;
                steps = m_el[m] / m_div[m];
                if (steps % m_t[m] == 0) begin
                    m_done[m] = 1'b1;
                    if (auto_reload) begin
                        m_cnt[m] = 0;
                    end else begin
                        m_cnt[m] = m_t[m];
                        m_act[m] = 1'b0;
                    end
                end else begin
                    m_cnt[m] = steps % m_t[m];
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_counter", 32'(ia.counter), 32'(m_cnt[0]));
        check("a_busy",    32'(ia.busy),    32'(m_act[0]));
        check("a_tick",    32'(ia.tick),    32'(m_tick[0]));
        check("a_done",    32'(ia.done),    32'(m_done[0]));
        check("b_counter", 32'(ib.counter), 32'(m_cnt[1]));
        check("b_busy",    32'(ib.busy),    32'(m_act[1]));
        check("b_tick",    32'(ib.tick),    32'(m_tick[1]));
        check("b_done",    32'(ib.done),    32'(m_done[1]));
    endtask

    // One active edge: inputs were set before it; check #1 after it.
    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0; terminal = 8'd0;
    endtask

    task automatic launch(input logic [7:0] t, input logic ar);
        terminal = t; auto_reload = ar; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic clear_both();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        m_div[0] = 4;
        m_div[1] = 1;
        model_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        repeat (2) cycle();

        // One-shot T=3 on DIV=4: ticks at 4, 8, 12; done after 12; counter holds 3.
        launch(8'd3, 1'b0);
        check("t1_busy_start", 32'(ia.busy), 32'd1);
        for (int e = 1; e <= 14; e++) begin
            cycle();
            if (e == 4 || e == 8 || e == 12) begin
                check("t1_tick", 32'(ia.tick), 32'd1);
                check("t1_counter", 32'(ia.counter), 32'(e / 4));
            end
            if (e == 12) begin
                check("t1_done", 32'(ia.done), 32'd1);
                check("t1_busy_fall", 32'(ia.busy), 32'd0);
            end
        end
        check("t1_counter_hold", 32'(ia.counter), 32'd3);
        check("t1_done_once", 32'(ia.done), 32'd0);

        // Auto-reload T=2 on DIV=1: counter 1,0,1,0 with done every 2 cycles.
        launch(8'd2, 1'b1);
        for (int e = 1; e <= 4; e++) begin
            cycle();
            check("t2_counter", 32'(ib.counter), 32'(e % 2));
            check("t2_done", 32'(ib.done), 32'(e % 2 == 0));
            check("t2_busy", 32'(ib.busy), 32'd1);
            check("t2_tick", 32'(ib.tick), 32'd1);
        end
        clear_both();

        // Pause for edges 6..10: done moves from edge 12 to edge 17.
        launch(8'd3, 1'b0);
        for (int e = 1; e <= 18; e++) begin
            pause = (e >= 6 && e <= 10);
            cycle();
            if (e >= 6 && e <= 10) check("t3_counter_frozen", 32'(ia.counter), 32'd1);
            if (e == 12 || e == 16) check("t3_no_early_done", 32'(ia.done), 32'd0);
            if (e == 17) check("t3_done", 32'(ia.done), 32'd1);
        end
        pause = 1'b0;

        // Abort at edge 7: idle and no done afterwards.
        launch(8'd3, 1'b0);
        for (int e = 1; e <= 26; e++) begin
            abort = (e == 7);
            cycle();
            if (e == 7) begin
                check("t4_busy", 32'(ia.busy), 32'd0);
                check("t4_counter", 32'(ia.counter), 32'd0);
            end
            if (e > 7) check("t4_no_done", 32'(ia.done), 32'd0);
        end
        abort = 1'b0;

        // Zero-length start: single done, busy stays low.
        launch(8'd0, 1'b0);
        check("t5_done_zero", 32'(ia.done), 32'd1);
        check("t5_busy_zero", 32'(ia.busy), 32'd0);
        cycle();
        check("t5_done_single", 32'(ia.done), 32'd0);

        // Restart with T=5 at edge 5: fresh interval completes at edge 25.
        launch(8'd3, 1'b0);
        repeat (4) cycle();
        launch(8'd5, 1'b0);
        check("t5_restart_counter", 32'(ia.counter), 32'd0);
        for (int e = 6; e <= 26; e++) begin
            cycle();
            if (e == 25) begin
                check("t5_restart_done", 32'(ia.done), 32'd1);
                check("t5_restart_final", 32'(ia.counter), 32'd5);
            end
        end

        // Restart coinciding with a terminal step suppresses done.
        launch(8'd2, 1'b0);
        repeat (7) cycle();
        launch(8'd2, 1'b0);
        check("t5_restart_wins", 32'(ia.done), 32'd0);
        check("t5_restart_busy", 32'(ia.busy), 32'd1);
        clear_both();

        // Full-range terminal on DIV=1.
        launch(8'd255, 1'b0);
        repeat (255) cycle();
        check("t7_max_done", 32'(ib.done), 32'd1);
        check("t7_max_counter", 32'(ib.counter), 32'd255);
        clear_both();

        // Async reset between edges mid-run.
        launch(8'd3, 1'b0);
        repeat (5) cycle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("t6_async_busy", 32'(ia.busy), 32'd0);
        #1;
        reset = 1'b0;
        repeat (6) cycle();
        check("t6_stays_idle", 32'(ia.busy), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            start       = ($urandom_range(0, 19) == 0);
            abort       = ($urandom_range(0, 49) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            auto_reload = 1'($urandom_range(0, 1));
            terminal    = 8'($urandom_range(0, 6));
            cycle();
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
